// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register: state encoding,
// default datapath widths and the hard-wired zero register address.
package id_ex_stage_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CTRL_W_DEF = 10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_t;

endpackage

// File: rtl/id_ex_entry.sv
// One held ID/EX instruction. It loads a new instruction when asked and
// keeps its operands current by snooping the register-file write port.
// A write to the entry's own source register wins over the loaded value,
// so a load and a matching write-back in the same cycle keep wb_wd.
module id_ex_entry
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [4:0]        ld_ra1,
    input  logic [4:0]        ld_ra2,
    input  logic [4:0]        ld_rt,
    input  logic [4:0]        ld_rd,
    input  logic [DATA_W-1:0] ld_srca,
    input  logic [DATA_W-1:0] ld_srcb,
    input  logic [DATA_W-1:0] ld_imm,
    input  logic [CTRL_W-1:0] ld_ctrl,
    input  logic              wb_we,
    input  logic [4:0]        wb_wa,
    input  logic [DATA_W-1:0] wb_wd,
    output logic [4:0]        ra1,
    output logic [4:0]        ra2,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [DATA_W-1:0] srca,
    output logic [DATA_W-1:0] srcb,
    output logic [DATA_W-1:0] imm,
    output logic [CTRL_W-1:0] ctrl
);

    logic [4:0]        ra1_nxt;
    logic [4:0]        ra2_nxt;
    logic [DATA_W-1:0] srca_nxt;
    logic [DATA_W-1:0] srcb_nxt;

    // Pick the loaded or held operands, then let a matching non-zero write-back override them
    always_comb begin
        ra1_nxt  = load ? ld_ra1  : ra1;
        ra2_nxt  = load ? ld_ra2  : ra2;
        srca_nxt = load ? ld_srca : srca;
        srcb_nxt = load ? ld_srcb : srcb;
        if (wb_we && (wb_wa == ra1_nxt) && (ra1_nxt != REG_ZERO)) begin
            srca_nxt = wb_wd;
        end
        if (wb_we && (wb_wa == ra2_nxt) && (ra2_nxt != REG_ZERO)) begin
            srcb_nxt = wb_wd;
        end
    end

    // Entry storage; reset clears every field so the outputs read as zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ra1  <= '0;
            ra2  <= '0;
            rt   <= '0;
            rd   <= '0;
            srca <= '0;
            srcb <= '0;
            imm  <= '0;
            ctrl <= '0;
        end else begin
            ra1  <= ra1_nxt;
            ra2  <= ra2_nxt;
            srca <= srca_nxt;
            srcb <= srcb_nxt;
            if (load) begin
                rt   <= ld_rt;
                rd   <= ld_rd;
                imm  <= ld_imm;
                ctrl <= ld_ctrl;
            end
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with a two-entry skid buffer. The main entry
// drives the execute side; the skid entry absorbs one extra instruction
// so in_ready can come straight from a flop.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        ra1,
    input  logic [4:0]        ra2,
    input  logic [DATA_W-1:0] rd1,
    input  logic [DATA_W-1:0] rd2,
    input  logic [DATA_W-1:0] imm,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [CTRL_W-1:0] ctrl,
    input  logic              wb_we,
    input  logic [4:0]        wb_wa,
    input  logic [DATA_W-1:0] wb_wd,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_srca,
    output logic [DATA_W-1:0] out_srcb,
    output logic [DATA_W-1:0] out_imm,
    output logic [4:0]        out_ra1,
    output logic [4:0]        out_ra2,
    output logic [4:0]        out_rt,
    output logic [4:0]        out_rd,
    output logic [CTRL_W-1:0] out_ctrl
);

    stage_state_t state;
    stage_state_t state_nxt;

    logic acc;
    logic deq;
    logic main_load;
    logic skid_load;
    logic main_from_skid;

    logic [DATA_W-1:0] a_in;
    logic [DATA_W-1:0] b_in;

    logic [4:0]        s_ra1, s_ra2, s_rt, s_rd;
    logic [DATA_W-1:0] s_srca, s_srcb, s_imm;
    logic [CTRL_W-1:0] s_ctrl;

    logic [4:0]        m_ld_ra1, m_ld_ra2, m_ld_rt, m_ld_rd;
    logic [DATA_W-1:0] m_ld_srca, m_ld_srcb, m_ld_imm;
    logic [CTRL_W-1:0] m_ld_ctrl;

    assign out_valid = (state != ST_EMPTY);
    assign acc       = in_valid && in_ready && !flush;
    assign deq       = out_valid && out_ready && !flush;

    assign a_in = (ra1 == REG_ZERO) ? '0 : rd1;
    assign b_in = (ra2 == REG_ZERO) ? '0 : rd2;

    assign m_ld_ra1  = main_from_skid ? s_ra1  : ra1;
    assign m_ld_ra2  = main_from_skid ? s_ra2  : ra2;
    assign m_ld_rt   = main_from_skid ? s_rt   : rt;
    assign m_ld_rd   = main_from_skid ? s_rd   : rd;
    assign m_ld_srca = main_from_skid ? s_srca : a_in;
    assign m_ld_srcb = main_from_skid ? s_srcb : b_in;
    assign m_ld_imm  = main_from_skid ? s_imm  : imm;
    assign m_ld_ctrl = main_from_skid ? s_ctrl : ctrl;

    // Occupancy transitions and which entry loads from where
    always_comb begin
        state_nxt      = state;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (acc) begin
                        state_nxt = ST_ONE;
                        main_load = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (acc && deq) begin
                        main_load = 1'b1;
                    end else if (acc) begin
                        state_nxt = ST_FULL;
                        skid_load = 1'b1;
                    end else if (deq) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (deq) begin
                        state_nxt      = ST_ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    // State and registered in_ready, which reflects room in the coming cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_EMPTY;
            in_ready <= 1'b0;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt != ST_FULL);
        end
    end

    id_ex_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clk     (clk),
        .reset   (reset),
        .load    (main_load),
        .ld_ra1  (m_ld_ra1),
        .ld_ra2  (m_ld_ra2),
        .ld_rt   (m_ld_rt),
        .ld_rd   (m_ld_rd),
        .ld_srca (m_ld_srca),
        .ld_srcb (m_ld_srcb),
        .ld_imm  (m_ld_imm),
        .ld_ctrl (m_ld_ctrl),
        .wb_we   (wb_we),
        .wb_wa   (wb_wa),
        .wb_wd   (wb_wd),
        .ra1     (out_ra1),
        .ra2     (out_ra2),
        .rt      (out_rt),
        .rd      (out_rd),
        .srca    (out_srca),
        .srcb    (out_srcb),
        .imm     (out_imm),
        .ctrl    (out_ctrl)
    );

    id_ex_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .load    (skid_load),
        .ld_ra1  (ra1),
        .ld_ra2  (ra2),
        .ld_rt   (rt),
        .ld_rd   (rd),
        .ld_srca (a_in),
        .ld_srcb (b_in),
        .ld_imm  (imm),
        .ld_ctrl (ctrl),
        .wb_we   (wb_we),
        .wb_wa   (wb_wa),
        .wb_wd   (wb_wd),
        .ra1     (s_ra1),
        .ra2     (s_ra2),
        .rt      (s_rt),
        .rd      (s_rd),
        .srca    (s_srca),
        .srcb    (s_srcb),
        .imm     (s_imm),
        .ctrl    (s_ctrl)
    );

endmodule
